// File: rtl/z_divider_seq_32.sv
// z_divider_seq_32 -- 32-bit sequential restoring divider.
//
// Runs one quotient bit per clock, MSB first, with a 32-step BUSY phase.
// A zero divisor skips BUSY and reports div_exception directly.
// Trial subtraction uses z_adder_select_4x8, a 32-bit adder built from
// four 8-bit carry-select slices.
//
// Build option: define DIV_SIGNED_EN for two's-complement operands.
// The core divides magnitudes, and the signs are applied on the final step.
// The quotient sign is dividend[31]^divisor[31].
// The remainder sign follows the dividend.
// Undefined (default): operands are unsigned and no sign logic is built.
//
// Ports:
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset
//   start         divide request, honoured only in IDLE
//   dividend      numerator, captured on the accepting edge
//   divisor       denominator, captured on the accepting edge
//   quotient      registered quotient
//   remainder     registered remainder
//   result_rdy    one-cycle pulse while in DONE; results valid
//   div_exception divisor was zero; valid with result_rdy
//   busy          high in BUSY and DONE

module z_adder_select_4x8 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  logic [4:0] carry;

  assign carry[0] = c_in;

  // Each slice precomputes both carry-in cases and selects on the ripple carry.
  for (genvar g = 0; g < 4; g++) begin : g_slice
    logic [8:0] sum0;
    logic [8:0] sum1;
    assign sum0 = {1'b0, a[g*8 +: 8]} + {1'b0, b[g*8 +: 8]};
    assign sum1 = {1'b0, a[g*8 +: 8]} + {1'b0, b[g*8 +: 8]} + 9'd1;
    assign sum[g*8 +: 8] = carry[g] ? sum1[7:0] : sum0[7:0];
    assign carry[g+1]    = carry[g] ? sum1[8]   : sum0[8];
  end

  assign c_out = carry[4];

endmodule

module z_divider_seq_32 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        result_rdy,
  output logic        div_exception,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [5:0]  step;
  logic [31:0] rem_acc;
  logic [31:0] quo_acc;
  logic [31:0] dvs_mag;

  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [31:0] shift_hi;
  logic [31:0] diff;
  logic        diff_carry;
  logic        take;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_final;
  logic [31:0] rem_final;
  logic        last_step;
  logic        divisor_zero;

`ifdef DIV_SIGNED_EN
  logic        quo_neg;
  logic        rem_neg;

  assign dividend_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
  assign divisor_mag  = divisor[31]  ? (~divisor  + 32'd1) : divisor;
  assign quo_final    = quo_neg ? (~quo_next + 32'd1) : quo_next;
  assign rem_final    = rem_neg ? (~rem_next + 32'd1) : rem_next;
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
  assign quo_final    = quo_next;
  assign rem_final    = rem_next;
`endif

  assign divisor_zero = (divisor == '0);
  assign last_step    = (step == 6'd31);

  // Shift {rem_acc, quo_acc} left by one. rem_acc[31] drops out of the
  // 32-bit window. When it is set, the shifted remainder is >= 2^32 > divisor.
  // The subtraction then always succeeds, and the 32-bit difference is exact.
  assign shift_hi = {rem_acc[30:0], quo_acc[31]};

  z_adder_select_4x8 u_trial_sub (
    .a     (shift_hi),
    .b     (~dvs_mag),
    .c_in  (1'b1),
    .sum   (diff),
    .c_out (diff_carry)
  );

  assign take     = diff_carry | rem_acc[31];
  assign rem_next = take ? diff : shift_hi;
  assign quo_next = {quo_acc[30:0], take};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = divisor_zero ? DONE : BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step          <= '0;
      rem_acc       <= '0;
      quo_acc       <= '0;
      dvs_mag       <= '0;
      quotient      <= '0;
      remainder     <= '0;
      div_exception <= 1'b0;
`ifdef DIV_SIGNED_EN
      quo_neg       <= 1'b0;
      rem_neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor_zero) begin
              quotient      <= '0;
              remainder     <= dividend;
              div_exception <= 1'b1;
            end else begin
              step    <= '0;
              rem_acc <= '0;
              quo_acc <= dividend_mag;
              dvs_mag <= divisor_mag;
`ifdef DIV_SIGNED_EN
              quo_neg <= dividend[31] ^ divisor[31];
              rem_neg <= dividend[31];
`endif
            end
          end
        end
        BUSY: begin
          rem_acc <= rem_next;
          quo_acc <= quo_next;
          step    <= step + 6'd1;
          if (last_step) begin
            quotient      <= quo_final;
            remainder     <= rem_final;
            div_exception <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_rdy = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: doc/z_divider_seq_32.md
Z_DIVIDER_SEQ_32 -- requirements
Module: z_divider_seq_32

Interface
REQ-001 clock  input  1  single rising-edge clock for all state.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request a divide; sampled on a rising clock edge, honoured only in IDLE.
REQ-004 dividend  input  32  numerator; captured on the accepting edge.
REQ-005 divisor  input  32  denominator; captured on the accepting edge.
REQ-006 quotient  output  32  registered result.
REQ-007 remainder  output  32  registered result.
REQ-008 result_rdy  output  1  one-cycle pulse; quotient, remainder and div_exception are valid while it is high.
REQ-009 div_exception  output  1  divisor was zero; valid with result_rdy.
REQ-010 busy  output  1  high in the BUSY and DONE states.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-012 IDLE to BUSY: on an edge with start=1 and divisor!=0, capture both operands and clear the step counter.
REQ-013 IDLE to DONE: on an edge with start=1 and divisor==0, set quotient=0, remainder=dividend and div_exception=1.
REQ-014 BUSY: one restoring-division step per edge, producing one quotient bit, MSB first; 6-bit step counter.
- Each step shifts {partial remainder, quotient} left by 1.
- Trial subtraction: partial remainder minus |divisor|, computed as a + ~b with c_in=1 on an instance of z_adder_select_4x8.
- A carry-out of 1 keeps the difference and sets the new quotient LSB to 1; otherwise the old value is restored and the LSB is 0.
REQ-015 BUSY to DONE on the edge that completes step 32; for a start accepted at edge k, result_rdy SHALL be high exactly between edges k+32 and k+33.
REQ-016 DONE to IDLE unconditionally on the next edge; result_rdy SHALL be high only in DONE.
REQ-017 quotient, remainder and div_exception SHALL hold their values after DONE until the next accepted start.
REQ-018 start asserted in BUSY or DONE SHALL be ignored, with no queuing.
REQ-019 A new start in the IDLE cycle immediately after DONE SHALL be accepted; back-to-back throughput is 34 cycles per divide.
REQ-020 div_exception SHALL be 0 for every non-zero divisor.
REQ-021 Operand inputs changing while in BUSY SHALL have no effect on the result.

Reset
REQ-022 reset_n=0 SHALL immediately force IDLE, clear the counter, and drive quotient, remainder, result_rdy, div_exception and busy to 0.
REQ-023 A reset asserted mid-division SHALL abort it: no result_rdy pulse, and IDLE on release.
REQ-024 The first start after reset release SHALL be accepted normally.

Configuration
REQ-025 Macro DIV_SIGNED_EN selects the number format.
- Defined:
  - Operands are two's complement and the magnitudes are divided.
  - Quotient sign = dividend[31] XOR divisor[31]; remainder sign follows the dividend; both are negated in the final step.
  - 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, div_exception 0.
- Undefined:
  - Operands are unsigned and no sign logic is synthesised.
- Latency and handshake are identical in both builds.

Verification
REQ-026 Unsigned build: start with 100 / 7 at edge k -> result_rdy only in cycle k+32..k+33, quotient=14, remainder=2.
REQ-027 Divide by zero: 0x12345678 / 0 -> result_rdy one cycle after the start edge, div_exception=1, quotient=0, remainder=0x12345678.
REQ-028 DIV_SIGNED_EN build: -7 / 2 -> quotient=-3, remainder=-1; and 0x80000000 / -1 -> quotient=0x80000000, remainder=0.
REQ-029 0xFFFFFFFF / 1 (unsigned build): second start pulsed mid-BUSY is ignored, operands changed mid-BUSY -> quotient=0xFFFFFFFF, remainder=0, and a single result_rdy pulse.
REQ-030 reset_n pulsed low at step 10 -> all outputs 0 at once, no result_rdy; then 9 / 3 -> quotient=3, remainder=0.
REQ-031 Back-to-back starts 50/5 then 51/5, second start in the IDLE cycle after DONE -> results 10 r 0 then 10 r 1, result_rdy pulses 34 cycles apart.
